// File: rtl/interp_ctrl_pkg.sv
// interp_ctrl_pkg: shared state encoding and default parameters for the interpolator controller
package interp_ctrl_pkg;
  localparam int INTERP_K     = 2;
  localparam int COEFF_NUM    = 16;
  localparam int COEFF_ADDR_W = 4;
  localparam int DATA_W       = 18;
  localparam int SAMPLE_GAP   = 16;
  localparam int FIFO_DEPTH   = 4;
  localparam int FLUSH_CYCLES = 4;
  typedef enum logic [1:0] {IDLE, FLUSH, LOAD, RUN} state_e;
endpackage

// File: rtl/interp_ctrl_fifo.sv
// interp_ctrl_fifo: sync FIFO, W x D; ports clk/rst, clr (flush), wr/wdata, rd, rdata (head), full, empty
module interp_ctrl_fifo #(
  parameter int W = 18,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem_q [D];
  logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
  logic         we, re;
  always_comb begin
    empty = wp_q == rp_q;
    full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    re    = rd && !empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO is still taken
    we    = wr && (!full || re);
    wp_d  = clr ? '0 : wp_q + (AW+1)'(we);
    rp_d  = clr ? '0 : rp_q + (AW+1)'(re);
    rdata = mem_q[rp_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we && !clr) mem_q[wp_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/interp_ctrl.sv
// interp_ctrl: loads interpolator coefficients from ROM, then paces source samples into it
//   Clk_i/Rst_i/Start_i control; CoeffRdAddr_o/CoeffRdData_i ROM side; CoeffAddr_o/CoeffData_o/CoeffWr_o/
//   InterpRst_o/Data_o/DataNd_o/DataValid_i interpolator side; Data_i/DataNd_i source; Ready_o/Busy_o/
//   Overflow_o/Spurious_o status
import interp_ctrl_pkg::*;
module interp_ctrl #(
  parameter int InterpolationK = INTERP_K,
  parameter int CoeffNum       = COEFF_NUM,
  parameter int CoeffAddrW     = COEFF_ADDR_W,
  parameter int DataW          = DATA_W,
  parameter int SampleGap      = SAMPLE_GAP,
  parameter int FifoDepth      = FIFO_DEPTH,
  parameter int FlushCycles    = FLUSH_CYCLES
) (
  input  logic                  Clk_i,
  input  logic                  Rst_i,
  input  logic                  Start_i,
  output logic [CoeffAddrW-1:0] CoeffRdAddr_o,
  input  logic [DataW-1:0]      CoeffRdData_i,
  output logic [CoeffAddrW-1:0] CoeffAddr_o,
  output logic [DataW-1:0]      CoeffData_o,
  output logic                  CoeffWr_o,
  output logic                  InterpRst_o,
  input  logic [DataW-1:0]      Data_i,
  input  logic                  DataNd_i,
  output logic [DataW-1:0]      Data_o,
  output logic                  DataNd_o,
  input  logic                  DataValid_i,
  output logic                  Ready_o,
  output logic                  Busy_o,
  output logic                  Overflow_o,
  output logic                  Spurious_o
);
  localparam int OW = $clog2(FifoDepth*InterpolationK+InterpolationK) + 1;
  localparam int GW = $clog2(SampleGap);
  localparam int FW = $clog2(FlushCycles) + 1;
  localparam int LW = CoeffAddrW + 1;
  state_e                state_q, state_d;
  logic [FW-1:0]         fl_q, fl_d;
  logic [LW-1:0]         ld_q, ld_d;
  logic                  cwr_q, cwr_d;
  logic [CoeffAddrW-1:0] caddr_q, caddr_d;
  logic [DataW-1:0]      dout_q, dout_d;
  logic                  dnd_q, dnd_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [OW-1:0]         out_q, out_d;
  logic                  ovf_q, ovf_d, spur_q, spur_d;
  logic                  clr, push, pop, vld, dec, full, empty;
  logic [DataW-1:0]      head;
  interp_ctrl_fifo #(.W(DataW), .D(FifoDepth)) u_fifo (
    .clk(Clk_i), .rst(Rst_i), .clr(clr), .wr(push), .wdata(Data_i),
    .rd(pop), .rdata(head), .full(full), .empty(empty)
  );
  always_comb begin
    clr     = Start_i || state_q == FLUSH;
    push    = state_q == RUN && !Start_i && DataNd_i;
    pop     = state_q == RUN && !Start_i && !empty && gap_q == '0;
    vld     = state_q == RUN && DataValid_i;
    // a valid arriving with the issue is counted against that issue, not flagged
    dec     = vld && (out_q != '0 || pop);
    state_d = state_q;
    fl_d    = fl_q;
    ld_d    = ld_q;
    cwr_d   = 1'b0;
    caddr_d = '0;
    if (Start_i) begin
      state_d = FLUSH;
      fl_d    = '0;
      ld_d    = '0;
    end else begin
      case (state_q)
        FLUSH: begin
          fl_d    = fl_q + 1'b1;
          state_d = fl_q == FW'(FlushCycles-1) ? LOAD : FLUSH;
        end
        // ld_q is the read address; the write of the previous address happens alongside it
        LOAD: begin
          if (ld_q == LW'(CoeffNum)) state_d = RUN;
          else begin
            ld_d    = ld_q + 1'b1;
            cwr_d   = 1'b1;
            caddr_d = ld_q[CoeffAddrW-1:0];
          end
        end
        default: ;
      endcase
    end
    dnd_d  = pop;
    dout_d = pop ? head : dout_q;
    gap_d  = clr ? '0 : pop ? GW'(SampleGap-1) : gap_q != '0 ? gap_q - 1'b1 : '0;
    out_d  = clr ? '0 : out_q + (pop ? OW'(InterpolationK) : '0) - OW'(dec);
    ovf_d  = !clr && (ovf_q || (push && full && !pop));
    spur_d = !clr && (spur_q || (vld && out_q == '0 && !pop));
  end
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q <= IDLE;
      fl_q    <= '0;
      ld_q    <= '0;
      cwr_q   <= 1'b0;
      caddr_q <= '0;
      dout_q  <= '0;
      dnd_q   <= 1'b0;
      gap_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fl_q    <= fl_d;
      ld_q    <= ld_d;
      cwr_q   <= cwr_d;
      caddr_q <= caddr_d;
      dout_q  <= dout_d;
      dnd_q   <= dnd_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      spur_q  <= spur_d;
    end
  end
  assign CoeffRdAddr_o = ld_q[CoeffAddrW-1:0];
  assign CoeffAddr_o   = caddr_q;
  assign CoeffData_o   = cwr_q ? CoeffRdData_i : '0;
  assign CoeffWr_o     = cwr_q;
  assign InterpRst_o   = state_q != RUN;
  assign Data_o        = dout_q;
  assign DataNd_o      = dnd_q;
  assign Ready_o       = state_q == RUN;
  assign Busy_o        = !empty || out_q != '0 || state_q != RUN;
  assign Overflow_o    = ovf_q;
  assign Spurious_o    = spur_q;
endmodule
